// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic array.
package sa_pkg;

  // Controller states: accept beats, let the skew wavefront drain, then emit rows.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FLUSH   = 2'd2,
    DRAIN   = 2'd3
  } sa_state_t;

  // Cycles after the last accepted beat until PE(N-1,N-1) has accumulated it.
  function automatic int saFlushCycles(input int n);
    return 2 * (n - 1);
  endfunction

  // Counter width able to hold 0 .. saFlushCycles(n).
  function automatic int saFlushW(input int n);
    return $clog2(saFlushCycles(n) + 1);
  endfunction

  // Row counter width for an n-row array.
  function automatic int saRowW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One multiply-accumulate cell: forwards A right, B down and the beat valid
// bit right, and keeps its own stationary partial sum.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 32,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [PSUM_W-1:0] o_acc
);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_valid;
  logic [PSUM_W-1:0] r_acc;
  logic [PSUM_W-1:0] w_prodExt;

  // Full-width product, extended to the accumulator width according to operand signedness.
  if (SIGNED != 0) begin : gSigned
    logic signed [2*DATA_W-1:0] w_prod;
    assign w_prod    = $signed(i_a) * $signed(i_b);
    assign w_prodExt = PSUM_W'(w_prod);
  end else begin : gUnsigned
    logic [2*DATA_W-1:0] w_prod;
    assign w_prod    = i_a * i_b;
    assign w_prodExt = PSUM_W'(w_prod);
  end

  // Forwarding registers and accumulator; clear wins, then accumulate only on a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_valid <= i_valid;
      if (i_clear) begin
        r_acc <= '0;
      end else if (i_valid) begin
        r_acc <= r_acc + w_prodExt;
      end
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_valid = r_valid;
  assign o_acc   = r_acc;

endmodule

// File: rtl/systolic_array_os.sv
// N x N output-stationary systolic matrix multiplier: skews incoming A columns
// and B rows, runs them through the PE grid, then drains C one row at a time.
module systolic_array_os
  import sa_pkg::*;
#(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int PSUM_W = 32,
  parameter int K_W    = 16,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_W-1:0]        k_len,
  input  logic                  clear_acc,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   a_in,
  input  logic [N*DATA_W-1:0]   b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*PSUM_W-1:0]   out_data,
  output logic [$clog2(N)-1:0]  out_row,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int ROW_W     = saRowW(N);
  localparam int FLUSH_CYC = saFlushCycles(N);
  localparam int FLUSH_W   = saFlushW(N);

  sa_state_t          r_state;
  logic [K_W-1:0]     r_kLen;
  logic [K_W-1:0]     r_beatCnt;
  logic [FLUSH_W-1:0] r_flushCnt;
  logic [ROW_W-1:0]   r_outRow;
  logic               r_inReady;
  logic               r_outValid;
  logic               r_outLast;
  logic               r_busy;
  logic               r_done;

  logic w_fire;
  logic w_clear;

  logic [DATA_W-1:0] w_aEdge [N];
  logic [DATA_W-1:0] w_bEdge [N];
  logic [N-1:0]      w_vEdge;

  logic [DATA_W-1:0] w_aFwd [N][N];
  logic [DATA_W-1:0] w_bFwd [N][N];
  logic              w_vFwd [N][N];
  logic [PSUM_W-1:0] w_acc  [N][N];

  logic [N-1:0] w_unusedA;
  logic [N-1:0] w_unusedB;

  assign w_fire  = r_inReady & in_valid;
  assign w_clear = (r_state == IDLE) & start & clear_acc;

  // Row i of A (and its valid bit) is delayed i cycles before entering column 0.
  for (genvar i = 0; i < N; i++) begin : gRowSkew
    if (i == 0) begin : gDirect
      assign w_aEdge[0] = a_in[0 +: DATA_W];
      assign w_vEdge[0] = w_fire;
    end else begin : gDelay
      logic [DATA_W-1:0] r_a [i];
      logic [i-1:0]      r_v;
      // Shift chain of depth i for the row operand and its valid bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < i; d++) r_a[d] <= '0;
          r_v <= '0;
        end else begin
          r_a[0] <= a_in[i*DATA_W +: DATA_W];
          r_v[0] <= w_fire;
          for (int d = 1; d < i; d++) begin
            r_a[d] <= r_a[d-1];
            r_v[d] <= r_v[d-1];
          end
        end
      end
      assign w_aEdge[i] = r_a[i-1];
      assign w_vEdge[i] = r_v[i-1];
    end
  end

  // Column j of B is delayed j cycles before entering row 0; validity rides with A.
  for (genvar j = 0; j < N; j++) begin : gColSkew
    if (j == 0) begin : gDirect
      assign w_bEdge[0] = b_in[0 +: DATA_W];
    end else begin : gDelay
      logic [DATA_W-1:0] r_b [j];
      // Shift chain of depth j for the column operand.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < j; d++) r_b[d] <= '0;
        end else begin
          r_b[0] <= b_in[j*DATA_W +: DATA_W];
          for (int d = 1; d < j; d++) r_b[d] <= r_b[d-1];
        end
      end
      assign w_bEdge[j] = r_b[j-1];
    end
  end

  // PE grid: A/valid enter from the left edge, B from the top edge.
  for (genvar i = 0; i < N; i++) begin : gRow
    for (genvar j = 0; j < N; j++) begin : gCol
      logic [DATA_W-1:0] w_aIn;
      logic [DATA_W-1:0] w_bIn;
      logic              w_vIn;
      if (j == 0) begin : gLeft
        assign w_aIn = w_aEdge[i];
        assign w_vIn = w_vEdge[i];
      end else begin : gInner
        assign w_aIn = w_aFwd[i][j-1];
        assign w_vIn = w_vFwd[i][j-1];
      end
      if (i == 0) begin : gTop
        assign w_bIn = w_bEdge[j];
      end else begin : gBelow
        assign w_bIn = w_bFwd[i-1][j];
      end
      sa_pe #(
        .DATA_W (DATA_W),
        .PSUM_W (PSUM_W),
        .SIGNED (SIGNED)
      ) uPe (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_valid (w_vIn),
        .i_a     (w_aIn),
        .i_b     (w_bIn),
        .o_valid (w_vFwd[i][j]),
        .o_a     (w_aFwd[i][j]),
        .o_b     (w_bFwd[i][j]),
        .o_acc   (w_acc[i][j])
      );
    end
  end

  // The right column and bottom row forward into nothing; fold them into a sink.
  for (genvar k = 0; k < N; k++) begin : gSink
    assign w_unusedA[k] = ^{w_aFwd[k][N-1], w_vFwd[k][N-1]};
    assign w_unusedB[k] = ^w_bFwd[N-1][k];
  end

  // Tile controller: beat counting, wavefront flush, row-serial drain with backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_kLen     <= '0;
      r_beatCnt  <= '0;
      r_flushCnt <= '0;
      r_outRow   <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_kLen    <= k_len;
            r_beatCnt <= '0;
            r_busy    <= 1'b1;
            if (k_len == '0) begin
              r_state    <= DRAIN;
              r_outValid <= 1'b1;
              r_outRow   <= '0;
              r_outLast  <= 1'b0;
            end else begin
              r_state   <= COMPUTE;
              r_inReady <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (w_fire) begin
            if (r_beatCnt == r_kLen - K_W'(1)) begin
              r_inReady  <= 1'b0;
              r_flushCnt <= '0;
              r_state    <= FLUSH;
            end else begin
              r_beatCnt <= r_beatCnt + K_W'(1);
            end
          end
        end
        FLUSH: begin
          if (r_flushCnt == FLUSH_W'(FLUSH_CYC - 1)) begin
            r_state    <= DRAIN;
            r_outValid <= 1'b1;
            r_outRow   <= '0;
            r_outLast  <= 1'b0;
          end else begin
            r_flushCnt <= r_flushCnt + FLUSH_W'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_outRow == ROW_W'(N - 1)) begin
              r_state    <= IDLE;
              r_outValid <= 1'b0;
              r_outLast  <= 1'b0;
              r_outRow   <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_outRow  <= r_outRow + ROW_W'(1);
              r_outLast <= (r_outRow == ROW_W'(N - 2));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Drain mux: the selected accumulator row, static while the array is draining.
  for (genvar j = 0; j < N; j++) begin : gOutMux
    assign out_data[j*PSUM_W +: PSUM_W] = w_acc[r_outRow][j];
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_row   = r_outRow;
  assign out_last  = r_outLast;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_systolic_array_os.sv
// Bench for systolic_array_os: drives tiles beat by beat and compares every
// drained row against a plain matrix-product model of C += A*B.
module tb_systolic_array_os;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int PW = 32;
  localparam int KW = 16;
  localparam int CW = N * PW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   kLen;
  logic            clearAcc;
  logic            inValid;
  logic            inReady;
  logic [N*DW-1:0] aIn;
  logic [N*DW-1:0] bIn;
  logic            outValid;
  logic            outReady;
  logic [CW-1:0]   outData;
  logic [2:0]      outRow;
  logic            outLast;
  logic            busy;
  logic            done;

  int checkCount = 0;
  int passCount  = 0;

  logic [PW-1:0] refC [N][N];
  logic [DW-1:0] constA;
  logic [DW-1:0] constB;

  systolic_array_os #(
    .N      (N),
    .DATA_W (DW),
    .PSUM_W (PW),
    .K_W    (KW),
    .SIGNED (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (kLen),
    .clear_acc (clearAcc),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a_in      (aIn),
    .b_in      (bIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_row   (outRow),
    .out_last  (outLast),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Global time bound so a wedged DUT cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, count a pass, or report the mismatch.
  task automatic checkValue(input string tag, input logic [CW-1:0] observed, input logic [CW-1:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Model row r of C packed the same way out_data is.
  function automatic logic [CW-1:0] modelRow(input int r);
    logic [CW-1:0] v;
    for (int j = 0; j < N; j++) v[j*PW +: PW] = refC[r][j];
    return v;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        refC[i][j] = '0;
  endtask

  // Start a tile and feed its beats. pattern: 0 constant, 1 identity, 2 random.
  // bubbleMode: 0 none, 1 bubble before every beat, 2 random bubbles.
  // stopAfter >= 0 abandons the tile after that many accepted beats.
  task automatic applyStimulus(input int kl, input bit clr, input int pattern, input int bubbleMode, input int stopAfter);
    logic [DW-1:0] av [N];
    logic [DW-1:0] bv [N];
    int t;
    @(negedge clk);
    start    = 1'b1;
    kLen     = KW'(kl);
    clearAcc = clr;
    if (clr) clearModel();
    @(negedge clk);
    start = 1'b0;
    checkValue("busy_after_start", CW'(busy), CW'(1));
    for (int k = 0; k < kl; k++) begin
      if (k == stopAfter) begin
        inValid = 1'b0;
        return;
      end
      if (bubbleMode == 1 || (bubbleMode == 2 && $urandom_range(0, 1) == 1)) begin
        inValid = 1'b0;
        aIn     = {$urandom, $urandom};
        bIn     = {$urandom, $urandom};
        @(negedge clk);
      end
      for (int i = 0; i < N; i++) begin
        case (pattern)
          0:       begin av[i] = constA; bv[i] = constB; end
          1:       begin av[i] = (i == k) ? DW'(1) : DW'(0); bv[i] = DW'(8 * k + i); end
          default: begin av[i] = DW'($urandom); bv[i] = DW'($urandom); end
        endcase
        aIn[i*DW +: DW] = av[i];
        bIn[i*DW +: DW] = bv[i];
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          refC[i][j] = refC[i][j] + PW'(int'($signed(av[i])) * int'($signed(bv[j])));
      inValid = 1'b1;
      t = 0;
      while (!inReady && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!inReady) begin
        checkValue("beat_accept_timeout", CW'(inReady), CW'(1));
        inValid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    inValid = 1'b0;
    if (kl > 0) checkValue("in_ready_after_last_beat", CW'(inReady), CW'(0));
  endtask

  // Wait for the drain and check every row; optionally stall one row and poke start meanwhile.
  task automatic checkOutput(input int stallRow, input int stallCycles);
    int t;
    t = 0;
    while (!outValid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!outValid) begin
      checkValue("drain_timeout", CW'(outValid), CW'(1));
      return;
    end
    for (int r = 0; r < N; r++) begin
      checkValue($sformatf("row%0d_valid", r), CW'(outValid), CW'(1));
      checkValue($sformatf("row%0d_index", r), CW'(outRow), CW'(r));
      checkValue($sformatf("row%0d_last", r), CW'(outLast), CW'(r == N - 1));
      checkValue($sformatf("row%0d_data", r), outData, modelRow(r));
      if (r == stallRow) begin
        outReady = 1'b0;
        start    = 1'b1;
        kLen     = KW'(5);
        clearAcc = 1'b1;
        for (int s = 0; s < stallCycles; s++) begin
          @(negedge clk);
          checkValue($sformatf("stall%0d_index", s), CW'(outRow), CW'(r));
          checkValue($sformatf("stall%0d_data", s), outData, modelRow(r));
        end
        start    = 1'b0;
        outReady = 1'b1;
      end
      @(negedge clk);
    end
    checkValue("done_pulse", CW'(done), CW'(1));
    checkValue("busy_after_drain", CW'(busy), CW'(0));
    checkValue("out_valid_after_drain", CW'(outValid), CW'(0));
    @(negedge clk);
    checkValue("done_single_cycle", CW'(done), CW'(0));
  endtask

  // Directed sequence of tiles.
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    kLen     = '0;
    clearAcc = 1'b0;
    inValid  = 1'b0;
    aIn      = '0;
    bIn      = '0;
    outReady = 1'b1;
    constA   = '0;
    constB   = '0;
    clearModel();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkValue("reset_busy", CW'(busy), CW'(0));
    checkValue("reset_in_ready", CW'(inReady), CW'(0));
    checkValue("reset_out_valid", CW'(outValid), CW'(0));
    checkValue("reset_out_last", CW'(outLast), CW'(0));
    checkValue("reset_done", CW'(done), CW'(0));
    checkValue("reset_out_row", CW'(outRow), CW'(0));
    checkValue("reset_out_data", outData, CW'(0));

    $display("[TB] constant tile k_len=25, expect 50");
    constA = 8'd2;
    constB = 8'd1;
    applyStimulus(25, 1'b1, 0, 0, -1);
    checkOutput(-1, 0);

    $display("[TB] identity tile k_len=8");
    applyStimulus(8, 1'b1, 1, 0, -1);
    checkOutput(-1, 0);

    $display("[TB] multi-pass accumulation, expect 100");
    applyStimulus(25, 1'b1, 0, 0, -1);
    checkOutput(-1, 0);
    applyStimulus(25, 1'b0, 0, 0, -1);
    checkOutput(-1, 0);
    applyStimulus(0, 1'b0, 0, 0, -1);
    checkOutput(-1, 0);

    $display("[TB] bubbles on input, stall on row 3");
    applyStimulus(25, 1'b1, 0, 1, -1);
    checkOutput(3, 3);

    $display("[TB] signed operands, expect -84");
    constA = 8'hFD;
    constB = 8'd7;
    applyStimulus(4, 1'b1, 0, 0, -1);
    checkOutput(-1, 0);

    $display("[TB] random operands with random bubbles, two passes");
    applyStimulus($urandom_range(1, 20), 1'b1, 2, 2, -1);
    checkOutput($urandom_range(0, N - 1), 2);
    applyStimulus($urandom_range(1, 20), 1'b0, 2, 2, -1);
    checkOutput(-1, 0);

    $display("[TB] reset in the middle of a tile");
    constA = 8'd2;
    constB = 8'd1;
    applyStimulus(25, 1'b1, 0, 0, 10);
    rst = 1'b1;
    @(negedge clk);
    checkValue("midreset_busy", CW'(busy), CW'(0));
    checkValue("midreset_out_valid", CW'(outValid), CW'(0));
    checkValue("midreset_in_ready", CW'(inReady), CW'(0));
    rst = 1'b0;
    clearModel();
    constA = 8'd1;
    constB = 8'd1;
    applyStimulus(1, 1'b0, 0, 0, -1);
    checkOutput(-1, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
